// File: rtl/tank_hit_scanner.sv
// Sequential bullet-vs-tank hit detector: snapshots positions on start, scans one bullet/tank pair per clock.
// Latency: pair k is evaluated k+1 cycles after start; a clean scan raises done NUM_BULLETS*NUM_TANKS+1 cycles after start.
// Backpressure: a hit holds the scan in REPORT with hit_valid high until hit_ack; all outputs are registered.
module tank_hit_scanner #(
    parameter int NUM_BULLETS = 6,
    parameter int NUM_TANKS   = 2,
    parameter int COORD_W     = 10,
    parameter int BIDX_W      = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1,
    parameter int TIDX_W      = (NUM_TANKS > 1) ? $clog2(NUM_TANKS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [NUM_BULLETS*COORD_W-1:0] bullet_x,
    input  logic [NUM_BULLETS*COORD_W-1:0] bullet_y,
    input  logic [NUM_BULLETS-1:0]         bullet_active,
    input  logic [NUM_TANKS*COORD_W-1:0]   tank_x,
    input  logic [NUM_TANKS*COORD_W-1:0]   tank_y,
    input  logic [COORD_W-1:0]             tank_size,
    input  logic                           round_clr,
    input  logic                           hit_ack,
    output logic                           hit_valid,
    output logic [BIDX_W-1:0]              hit_bullet,
    output logic [TIDX_W-1:0]              hit_tank,
    output logic [NUM_BULLETS-1:0]         bullet_clr,
    output logic [NUM_TANKS-1:0]           tank_dead,
    output logic                           busy,
    output logic                           done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_REPORT,
        S_DONE
    } state_t;

    state_t state_q;

    // Frame snapshot: inputs are only looked at on the start cycle.
    logic [COORD_W-1:0]     bx_q [NUM_BULLETS];
    logic [COORD_W-1:0]     by_q [NUM_BULLETS];
    logic [NUM_BULLETS-1:0] act_q;
    logic [COORD_W-1:0]     tx_q [NUM_TANKS];
    logic [COORD_W-1:0]     ty_q [NUM_TANKS];
    logic [COORD_W-1:0]     size_q;

    // Pair counter, b-major.
    logic [BIDX_W-1:0] b_q;
    logic [TIDX_W-1:0] t_q;

    // Registered outputs.
    logic                   hit_valid_q;
    logic [BIDX_W-1:0]      hit_bullet_q;
    logic [TIDX_W-1:0]      hit_tank_q;
    logic [NUM_BULLETS-1:0] bullet_clr_q;
    logic [NUM_TANKS-1:0]   tank_dead_q;
    logic                   busy_q;
    logic                   done_q;

    // Pair evaluation terms for the current (b,t).
    logic [COORD_W-1:0] cur_bx_d;
    logic [COORD_W-1:0] cur_by_d;
    logic [COORD_W-1:0] cur_tx_d;
    logic [COORD_W-1:0] cur_ty_d;
    logic [COORD_W-1:0] lo_x_d;
    logic [COORD_W-1:0] lo_y_d;
    logic [COORD_W:0]   hi_x_d;
    logic [COORD_W:0]   hi_y_d;
    logic               in_x_d;
    logic               in_y_d;
    logic               pair_hit_d;
    logic               last_t_d;
    logic               last_b_d;
    logic               last_hit_b_d;

    // Box test for the pair under the counter; lower bound saturates at 0, upper bound carries an extra bit.
    always_comb begin
        cur_bx_d = bx_q[b_q];
        cur_by_d = by_q[b_q];
        cur_tx_d = tx_q[t_q];
        cur_ty_d = ty_q[t_q];

        lo_x_d = (cur_tx_d >= size_q) ? (cur_tx_d - size_q) : '0;
        lo_y_d = (cur_ty_d >= size_q) ? (cur_ty_d - size_q) : '0;
        hi_x_d = {1'b0, cur_tx_d} + {1'b0, size_q};
        hi_y_d = {1'b0, cur_ty_d} + {1'b0, size_q};

        in_x_d = (cur_bx_d >= lo_x_d) && ({1'b0, cur_bx_d} <= hi_x_d);
        in_y_d = (cur_by_d >= lo_y_d) && ({1'b0, cur_by_d} <= hi_y_d);

        // A tank already killed this round (even earlier in this scan) cannot be hit again.
        pair_hit_d = act_q[b_q] && !tank_dead_q[t_q] && in_x_d && in_y_d;

        last_t_d     = (t_q == TIDX_W'(NUM_TANKS - 1));
        last_b_d     = (b_q == BIDX_W'(NUM_BULLETS - 1));
        last_hit_b_d = (hit_bullet_q == BIDX_W'(NUM_BULLETS - 1));
    end

    // Scan FSM with snapshot capture, pair counter, hit handshake and sticky dead flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            b_q          <= '0;
            t_q          <= '0;
            act_q        <= '0;
            size_q       <= '0;
            hit_valid_q  <= 1'b0;
            hit_bullet_q <= '0;
            hit_tank_q   <= '0;
            bullet_clr_q <= '0;
            tank_dead_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                bx_q[i] <= '0;
                by_q[i] <= '0;
            end
            for (int j = 0; j < NUM_TANKS; j++) begin
                tx_q[j] <= '0;
                ty_q[j] <= '0;
            end
        end else begin
            // Pulse outputs default low; they are raised only on the transition that owns them.
            bullet_clr_q <= '0;
            done_q       <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NUM_BULLETS; i++) begin
                            bx_q[i] <= bullet_x[i*COORD_W +: COORD_W];
                            by_q[i] <= bullet_y[i*COORD_W +: COORD_W];
                        end
                        for (int j = 0; j < NUM_TANKS; j++) begin
                            tx_q[j] <= tank_x[j*COORD_W +: COORD_W];
                            ty_q[j] <= tank_y[j*COORD_W +: COORD_W];
                        end
                        act_q   <= bullet_active;
                        size_q  <= tank_size;
                        b_q     <= '0;
                        t_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SCAN;
                    end
                end

                S_SCAN: begin
                    if (pair_hit_d) begin
                        hit_bullet_q <= b_q;
                        hit_tank_q   <= t_q;
                        hit_valid_q  <= 1'b1;
                        state_q      <= S_REPORT;
                    end else if (last_t_d) begin
                        t_q <= '0;
                        if (last_b_d) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            b_q <= b_q + 1'b1;
                        end
                    end else begin
                        t_q <= t_q + 1'b1;
                    end
                end

                S_REPORT: begin
                    if (hit_ack) begin
                        hit_valid_q                <= 1'b0;
                        bullet_clr_q[hit_bullet_q] <= 1'b1;
                        tank_dead_q[hit_tank_q]    <= 1'b1;
                        // The consumed bullet is gone, so its remaining tanks are skipped.
                        t_q <= '0;
                        if (last_hit_b_d) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            b_q     <= hit_bullet_q + 1'b1;
                            state_q <= S_SCAN;
                        end
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            // Round clear overrides any dead flag being set by an ack on the same edge.
            if (round_clr) begin
                tank_dead_q <= '0;
            end
        end
    end

    assign hit_valid  = hit_valid_q;
    assign hit_bullet = hit_bullet_q;
    assign hit_tank   = hit_tank_q;
    assign bullet_clr = bullet_clr_q;
    assign tank_dead  = tank_dead_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
